// File: rtl/btb_set_assoc_if.sv
// Fetch/resolve/flush bus between the core front end and the set-associative BTB.
interface btb_set_assoc_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] lookup_pc;
  logic            pred_hit;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            flush;
  logic            busy;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
    input  pred_hit, pred_target, busy
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
    output pred_hit, pred_target, busy
  );
endinterface

// File: rtl/btb_set_assoc.sv
// Set-associative BTB with pseudo-LRU replacement and a sequenced flush.
// Optional feature: define BTB_CONF_EN for per-entry 2-bit confidence counters.
module btb_set_assoc #(
  parameter int PC_W = 16,
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic           clk,
  input  logic           rst,
  btb_set_assoc_if.slave bus
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = PC_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS == 4) ? 3 : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] set_cnt_q, set_cnt_d;
  logic             clear_en;
  logic             busy;

  logic [WAYS-1:0]   valid_q  [SETS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [PC_W-1:0]   target_q [SETS][WAYS];
  logic [PLRU_W-1:0] plru_q   [SETS];
`ifdef BTB_CONF_EN
  logic [1:0] conf_q [SETS][WAYS];
  logic [1:0] conf_cur, conf_d;
`endif

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [WAYS-1:0]  look_qual;
  logic             look_match;
  logic [PC_W-1:0]  look_target;
  logic             pred_hit;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit, inv_found, upd_acc, upd_write;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_victim, wr_way;
  logic [PLRU_W-1:0] plru_set, plru_next;

  assign look_idx = bus.lookup_pc[IDX_W-1:0];
  assign look_tag = bus.lookup_pc[PC_W-1:IDX_W];
  assign upd_idx  = bus.upd_pc[IDX_W-1:0];
  assign upd_tag  = bus.upd_pc[PC_W-1:IDX_W];

`ifdef BTB_CONF_EN
  // Only entries with a weakly/strongly taken counter predict.
  always_comb begin
    look_qual = '0;
    for (int w = 0; w < WAYS; w++) begin
      look_qual[w] = conf_q[look_idx][w][1];
    end
  end
`else
  assign look_qual = '1;
`endif

  always_comb begin
    look_match  = 1'b0;
    look_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[look_idx][w] && (tag_q[look_idx][w] == look_tag) && look_qual[w]) begin
        look_match  = 1'b1;
        look_target = look_target | target_q[look_idx][w];
      end
    end
  end

  assign busy            = (state_q == FLUSH);
  assign pred_hit        = look_match && !busy;
  assign bus.pred_hit    = pred_hit;
  assign bus.pred_target = pred_hit ? look_target : '0;
  assign bus.busy        = busy;

  // Tag hits ignore the confidence counter; descending scan leaves the lowest invalid way.
  always_comb begin
    upd_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign plru_set = plru_q[upd_idx];

  if (WAYS == 4) begin : g_plru4
    // Bit 0 selects the LRU pair, bits 1/2 the LRU way inside the left/right pair.
    assign plru_victim = plru_set[0] ? {1'b1, plru_set[2]} : {1'b0, plru_set[1]};
    always_comb begin
      plru_next    = plru_set;
      plru_next[0] = ~wr_way[1];
      if (wr_way[1]) plru_next[2] = ~wr_way[0];
      else           plru_next[1] = ~wr_way[0];
    end
  end else if (WAYS == 2) begin : g_plru2
    assign plru_victim = plru_set;
    assign plru_next   = ~wr_way;
  end else begin : g_plru1
    assign plru_victim = 1'b0;
    assign plru_next   = 1'b0;
  end

  assign wr_way    = upd_hit ? hit_way : (inv_found ? inv_way : plru_victim);
  assign upd_acc   = bus.upd_valid && (state_q == IDLE) && !bus.flush;
  assign upd_write = upd_acc && (upd_hit || bus.upd_taken);

`ifdef BTB_CONF_EN
  always_comb begin
    conf_cur = conf_q[upd_idx][hit_way];
    conf_d   = 2'b10;
    if (upd_hit) begin
      conf_d = conf_cur;
      if (bus.upd_taken && (conf_cur != 2'b11))       conf_d = conf_cur + 2'd1;
      else if (!bus.upd_taken && (conf_cur != 2'b00)) conf_d = conf_cur - 2'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    clear_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d   = FLUSH;
          set_cnt_d = '0;
        end
      end
      FLUSH: begin
        clear_en = 1'b1;
        if (bus.flush) begin
          set_cnt_d = '0;
        end else if (set_cnt_q == IDX_W'(SETS - 1)) begin
          state_d   = IDLE;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid and PLRU are the only reset state; a not-taken write can only be a tag hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (clear_en) begin
      valid_q[set_cnt_q] <= '0;
      plru_q[set_cnt_q]  <= '0;
    end else if (upd_write) begin
`ifdef BTB_CONF_EN
      valid_q[upd_idx][wr_way] <= 1'b1;
      plru_q[upd_idx]          <= plru_next;
`else
      if (bus.upd_taken) begin
        valid_q[upd_idx][wr_way] <= 1'b1;
        plru_q[upd_idx]          <= plru_next;
      end else begin
        valid_q[upd_idx][wr_way] <= 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (upd_write) begin
      tag_q[upd_idx][wr_way]    <= upd_tag;
      target_q[upd_idx][wr_way] <= bus.upd_target;
`ifdef BTB_CONF_EN
      conf_q[upd_idx][wr_way]   <= conf_d;
`endif
    end
  end
endmodule

// File: tb/tb_btb_set_assoc.sv
// Randomized self-checking bench for btb_set_assoc against a set/way reference model.
module tb_btb_set_assoc;
  localparam int PC_W = 16;
  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic clk = 1'b0;
  logic rst;

  btb_set_assoc_if #(.PC_W(PC_W)) bus ();

  btb_set_assoc #(.PC_W(PC_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: flush wipes everything up front and only counts down busy cycles.
  bit m_valid  [SETS][WAYS];
  int m_tag    [SETS][WAYS];
  int m_target [SETS][WAYS];
  int m_cnt    [SETS][WAYS];
  int m_mru    [SETS];
  int busy_left;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_wipe();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      m_mru[s] = WAYS - 1;
    end
  endtask

  task automatic model_reset();
    model_wipe();
    busy_left = 0;
  endtask

  task automatic model_lookup(input logic [15:0] pc, output bit hit, output logic [15:0] tgt);
    int s = int'(pc) % SETS;
    int t = int'(pc) / SETS;
    hit = 1'b0;
    tgt = '0;
    if (busy_left == 0) begin
      for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_CONF_EN
        if (m_valid[s][w] && m_tag[s][w] == t && m_cnt[s][w] >= 2) begin
`else
        if (m_valid[s][w] && m_tag[s][w] == t) begin
`endif
          hit = 1'b1;
          tgt = 16'(m_target[s][w]);
        end
      end
    end
  endtask

  task automatic model_edge(input bit uv, input logic [15:0] upc, input bit ut,
                            input logic [15:0] utgt, input bit fl);
    int s = int'(upc) % SETS;
    int t = int'(upc) / SETS;
    int hw = -1;
    int v = -1;
    if (busy_left > 0) begin
      busy_left = fl ? SETS : busy_left - 1;
      return;
    end
    if (fl) begin
      model_wipe();
      busy_left = SETS;
      return;
    end
    if (!uv) return;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      m_target[s][hw] = int'(utgt);
`ifdef BTB_CONF_EN
      if (ut) m_cnt[s][hw] = (m_cnt[s][hw] == 3) ? 3 : m_cnt[s][hw] + 1;
      else    m_cnt[s][hw] = (m_cnt[s][hw] == 0) ? 0 : m_cnt[s][hw] - 1;
      m_mru[s] = hw;
`else
      if (ut) m_mru[s] = hw;
      else    m_valid[s][hw] = 1'b0;
`endif
    end else if (ut) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = 1 - m_mru[s];
      m_valid[s][v]  = 1'b1;
      m_tag[s][v]    = t;
      m_target[s][v] = int'(utgt);
      m_cnt[s][v]    = 2;
      m_mru[s]       = v;
    end
  endtask

  // One clock: drive, compare at the falling edge, then advance the model on the rising edge.
  task automatic applyStimulus(input logic [15:0] lpc, input bit uv, input logic [15:0] upc,
                               input bit ut, input logic [15:0] utgt, input bit fl,
                               input string name);
    bit          e_hit;
    logic [15:0] e_tgt;
    bus.lookup_pc  = lpc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utgt;
    bus.flush      = fl;
    @(negedge clk);
    model_lookup(lpc, e_hit, e_tgt);
    checkOutput({name, "_hit"},  32'(bus.pred_hit),    32'(e_hit));
    checkOutput({name, "_tgt"},  32'(bus.pred_target), 32'(e_tgt));
    checkOutput({name, "_busy"}, 32'(bus.busy),        32'(busy_left > 0));
    @(posedge clk);
    model_edge(uv, upc, ut, utgt, fl);
    #1;
  endtask

  task automatic lookupExpect(input logic [15:0] pc, input bit exp_hit,
                              input logic [15:0] exp_tgt, input string name);
    bus.lookup_pc = pc;
    bus.upd_valid = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    checkOutput({name, "_hit"}, 32'(bus.pred_hit),    32'(exp_hit));
    checkOutput({name, "_tgt"}, 32'(bus.pred_target), 32'(exp_tgt));
    @(posedge clk);
    model_edge(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
  endtask

  initial begin
    logic [15:0] lpc, upc;
    rst            = 1'b1;
    bus.lookup_pc  = 16'h0013;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    bus.flush      = 1'b0;
    model_reset();
    #3;
    checkOutput("reset_hit",  32'(bus.pred_hit),    32'd0);
    checkOutput("reset_tgt",  32'(bus.pred_target), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy),        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(16'h0013, 1, 16'h0013, 1, 16'h0100, 0, "inst13");
    lookupExpect(16'h0013, 1, 16'h0100, "hit13");
    lookupExpect(16'h0023, 0, 16'h0000, "miss23");

    applyStimulus(16'h0000, 1, 16'h0023, 1, 16'h0200, 0, "inst23");
    applyStimulus(16'h0000, 1, 16'h0013, 1, 16'h0100, 0, "touch13");
    applyStimulus(16'h0000, 1, 16'h0033, 1, 16'h0300, 0, "inst33");
    lookupExpect(16'h0023, 0, 16'h0000, "evict23");
    lookupExpect(16'h0013, 1, 16'h0100, "keep13");
    lookupExpect(16'h0033, 1, 16'h0300, "new33");

    applyStimulus(16'h0000, 1, 16'h0045, 1, 16'h0450, 0, "inst45");
    applyStimulus(16'h0000, 1, 16'h0045, 0, 16'h0450, 0, "nt45");
    lookupExpect(16'h0045, 0, 16'h0000, "nt45_miss");
`ifdef BTB_CONF_EN
    applyStimulus(16'h0000, 1, 16'h0045, 1, 16'h0450, 0, "t45");
    lookupExpect(16'h0045, 1, 16'h0450, "conf45_hit");
`endif

    for (int s = 0; s < SETS; s++)
      applyStimulus(16'h0000, 1, 16'h0100 | 16'(s), 1, 16'h1000 + 16'(s), 0, "fill");
    lookupExpect(16'h0105, 1, 16'h1005, "fill_hit");
    applyStimulus(16'h0105, 0, 16'h0000, 0, 16'h0000, 1, "flush_req");
    for (int i = 0; i < SETS; i++) begin
      bus.lookup_pc = 16'h0100 | 16'(i);
      #1;
      checkOutput("flush_busy", 32'(bus.busy),     32'd1);
      checkOutput("flush_hit",  32'(bus.pred_hit), 32'd0);
      applyStimulus(16'h0100 | 16'(i), i == 3, 16'h0107, 1, 16'h7777, 0, "flushing");
    end
    #1;
    checkOutput("flush_done", 32'(bus.busy), 32'd0);
    for (int s = 0; s < SETS; s++)
      lookupExpect(16'h0100 | 16'(s), 0, 16'h0000, "post_flush");
    lookupExpect(16'h0013, 0, 16'h0000, "post_flush13");

    applyStimulus(16'h0000, 1, 16'h0013, 1, 16'h0AAA, 0, "refill13");
    applyStimulus(16'h0013, 0, 16'h0000, 0, 16'h0000, 1, "flush2");
    for (int i = 0; i < 4; i++)
      applyStimulus(16'h0013, 0, 16'h0000, 0, 16'h0000, 0, "flush2_run");
    bus.lookup_pc = 16'h0013;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 32'(bus.busy),        32'd0);
    checkOutput("rst_mid_hit",  32'(bus.pred_hit),    32'd0);
    checkOutput("rst_mid_tgt",  32'(bus.pred_target), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(16'h0000, 1, 16'h0013, 1, 16'h0BCD, 0, "post_rst_inst");
    lookupExpect(16'h0013, 1, 16'h0BCD, "post_rst_hit");

    bus.lookup_pc = 16'h0013;
    #1;
    checkOutput("pre_rst_hit", 32'(bus.pred_hit), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_hit", 32'(bus.pred_hit),    32'd0);
    checkOutput("async_rst_tgt", 32'(bus.pred_target), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      lpc = {12'($urandom_range(0, 3)), 4'($urandom_range(0, 5))};
      upc = {12'($urandom_range(0, 3)), 4'($urandom_range(0, 5))};
      if ($urandom_range(0, 15) == 0) lpc[15:4] = 12'hABC;
      applyStimulus(lpc, $urandom_range(0, 1) == 1, upc, $urandom_range(0, 9) < 7,
                    16'($urandom), $urandom_range(0, 63) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
